// File: rtl/fpga_mode_pkg.sv
// Shared types and defaults for the FPGA HF/LF mode switch controller.
package fpga_mode_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DEBOUNCE   = 3'd1,
    WAIT_SPI   = 3'd2,
    BLANK_PRE  = 3'd3,
    SWAP       = 3'd4,
    BLANK_POST = 3'd5
  } mode_state_e;

  localparam logic SEL_LF = 1'b0;
  localparam logic SEL_HF = 1'b1;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1024;
  localparam int DEF_GUARD_CYCLES    = 64;
  localparam int DEF_TIMEOUT_CYCLES  = 65536;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fpga_sync_ff.sv
// Single-bit multi-flop synchroniser for asynchronous inputs.
module fpga_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_mode_switch_ctrl.sv
// HF/LF mode switch sequencer: debounce, wait for SPI idle, blank, swap, blank.
// Optional SPI-idle timeout enabled by defining MODE_SWITCH_TIMEOUT_EN.
module fpga_mode_switch_ctrl
  import fpga_mode_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   GUARD_CYCLES    = DEF_GUARD_CYCLES,
  parameter logic RESET_SEL       = SEL_LF,
  parameter int   TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic pck0,
  input  logic rst,
  input  logic switch_req,
  input  logic ncs,
  output logic sel,
  output logic blank,
  output logic busy,
  output logic mode_changed,
  output logic spi_forced
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, GUARD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic req_s, ncs_s;
  mode_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic sel_d, blank_d, busy_d, mc_d;

  fpga_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(pck0), .rst(rst), .d(switch_req), .q(req_s)
  );

  fpga_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(pck0), .rst(rst), .d(ncs), .q(ncs_s)
  );

  // State and dwell counter; the counter restarts on every state change and saturates
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req_s != sel) state_nxt = DEBOUNCE;
      DEBOUNCE:   if (req_s == sel) state_nxt = IDLE;
                  else if (cnt == DEB_LAST) state_nxt = WAIT_SPI;
      WAIT_SPI:   if (req_s == sel) state_nxt = IDLE;
                  else if (ncs_s) state_nxt = BLANK_PRE;
`ifdef MODE_SWITCH_TIMEOUT_EN
                  else if (cnt == TO_LAST) state_nxt = BLANK_PRE;
`endif
      BLANK_PRE:  if (cnt == GRD_LAST) state_nxt = SWAP;
      SWAP:       state_nxt = BLANK_POST;
      BLANK_POST: if (cnt == GRD_LAST) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    cnt_nxt = cnt;
    if (state_nxt != state) cnt_nxt = '0;
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Outputs are computed from the upcoming state so they register in step with it
  always_comb begin
    blank_d = (state_nxt == BLANK_PRE) || (state_nxt == SWAP) || (state_nxt == BLANK_POST);
    busy_d  = (state_nxt != IDLE);
    mc_d    = (state == SWAP);
    sel_d   = (state == SWAP) ? ~sel : sel;
  end

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      sel          <= RESET_SEL;
      blank        <= 1'b0;
      busy         <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      sel          <= sel_d;
      blank        <= blank_d;
      busy         <= busy_d;
      mode_changed <= mc_d;
    end
  end

`ifdef MODE_SWITCH_TIMEOUT_EN
  // Sticky record that a swap was forced while SPI was still active
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) spi_forced <= 1'b0;
    else if (state == WAIT_SPI && state_nxt == BLANK_PRE && !ncs_s) spi_forced <= 1'b1;
  end
`else
  assign spi_forced = 1'b0;
`endif

endmodule
